// File: rtl/mips_muldiv_unit_pkg.sv
// Shared constants for the MIPS multiply/divide unit: op codes, FSM state
// encodings and the status-bit positions shared with the ALU.
package mips_muldiv_unit_pkg;

    // Operation codes
    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    // FSM state encodings
    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_CALC = 2'd1;
    localparam logic [1:0] MD_FIX  = 2'd2;

    // Status bit positions ({V,N,Z,C}), identical to the ALU
    localparam int unsigned STATUS_WIDTH = 4;
    localparam int unsigned STATUS_C_BIT = 0;
    localparam int unsigned STATUS_Z_BIT = 1;
    localparam int unsigned STATUS_N_BIT = 2;
    localparam int unsigned STATUS_V_BIT = 3;

    // MULT and DIV work on magnitudes and fix the sign up afterwards
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mips_abs_neg.sv
// Conditional two's-complement negate / absolute value.
//   a        : input operand
//   abs_mode : 1 -> y_c = |a| (negate when a is negative); 0 -> use neg
//   neg      : negate request when abs_mode == 0
//   y_c      : combinational result
module mips_abs_neg #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic                  abs_mode,
    input  logic                  neg,
    output logic [DATA_WIDTH-1:0] y_c
);

    logic flip;

    assign flip = abs_mode ? a[DATA_WIDTH-1] : neg;
    assign y_c  = flip ? (~a + DATA_WIDTH'(1)) : a;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
//   clk, rst_n           : clock, async active-low reset
//   start, op, a, b      : launch MULT/MULTU/DIV/DIVU (accepted when busy==0)
//   hi_we, lo_we, wdata  : MTHI/MTLO writes (only while idle and start==0)
//   busy                 : operation in progress
//   done                 : one-cycle pulse when hi/lo/status_out are updated
//   hi, lo               : product halves / remainder, quotient
//   status_out           : {V,N,Z,C} at the ALU status bit positions
module mips_muldiv_unit
    import mips_muldiv_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    input  logic                    hi_we,
    input  logic                    lo_we,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   hi,
    output logic [DATA_WIDTH-1:0]   lo,
    output logic [STATUS_WIDTH-1:0] status_out
);

    localparam int unsigned W          = DATA_WIDTH;
    localparam int unsigned AW         = 2 * DATA_WIDTH;
    localparam int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH + 1);
    localparam logic [W-1:0] MIN_NEG   = {1'b1, {(W-1){1'b0}}};

    logic [1:0]              state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [1:0]              op_q, op_d;
    logic [AW-1:0]           acc_q, acc_d;
    logic [W-1:0]            opb_q, opb_d;
    logic                    neg_q, neg_d;
    logic                    neg_rem_q, neg_rem_d;
    logic                    special_q, special_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [W-1:0]            hi_q, hi_d;
    logic [W-1:0]            lo_q, lo_d;
    logic [STATUS_WIDTH-1:0] status_q, status_d;

    logic                    sgn;
    logic                    div_zero;
    logic                    div_ovf;
    logic [W-1:0]            a_abs, b_abs;
    logic [AW-1:0]           prod_c;
    logic [W-1:0]            quot_c, rem_c;
    logic [W:0]              mul_sum;
    logic [AW-1:0]           mul_next;
    logic [W:0]              div_sh, div_diff;
    logic [AW-1:0]           div_next;
    logic [W-1:0]            res_hi, res_lo;
    logic [STATUS_WIDTH-1:0] res_status;

    assign busy       = busy_q;
    assign done       = done_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign status_out = status_q;

    assign sgn      = op_is_signed(op);
    assign div_zero = op[1] && (b == '0);
    assign div_ovf  = (op == MD_DIV) && (a == MIN_NEG) && (b == '1);

    // Operand magnitudes for signed ops
    mips_abs_neg #(.DATA_WIDTH(W)) u_abs_a (.a(a), .abs_mode(sgn), .neg(1'b0), .y_c(a_abs));
    mips_abs_neg #(.DATA_WIDTH(W)) u_abs_b (.a(b), .abs_mode(sgn), .neg(1'b0), .y_c(b_abs));

    // Sign fix-up of product, quotient and remainder
    mips_abs_neg #(.DATA_WIDTH(AW)) u_fix_prod (.a(acc_q), .abs_mode(1'b0), .neg(neg_q), .y_c(prod_c));
    mips_abs_neg #(.DATA_WIDTH(W)) u_fix_quot (.a(acc_q[W-1:0]), .abs_mode(1'b0), .neg(neg_q), .y_c(quot_c));
    mips_abs_neg #(.DATA_WIDTH(W)) u_fix_rem (.a(acc_q[AW-1:W]), .abs_mode(1'b0), .neg(neg_rem_q), .y_c(rem_c));

    // One multiply step: add multiplicand to upper half when multiplier lsb set, then shift right
    assign mul_sum  = acc_q[0] ? ({1'b0, acc_q[AW-1:W]} + {1'b0, opb_q}) : {1'b0, acc_q[AW-1:W]};
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // One restoring-divide step: acc = {remainder, dividend/quotient}
    assign div_sh   = {acc_q[AW-1:W], acc_q[W-1]};
    assign div_diff = div_sh - {1'b0, opb_q};
    assign div_next = div_diff[W] ? {div_sh[W-1:0], acc_q[W-2:0], 1'b0}
                                  : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};

    // Final hi/lo/status from the accumulator
    always_comb begin
        res_hi     = acc_q[AW-1:W];
        res_lo     = acc_q[W-1:0];
        res_status = '0;
        if (special_q) begin
            res_status[STATUS_V_BIT] = 1'b1;
            res_status[STATUS_N_BIT] = res_lo[W-1];
            res_status[STATUS_Z_BIT] = (res_lo == '0);
        end else if (!op_q[1]) begin
            res_hi                   = prod_c[AW-1:W];
            res_lo                   = prod_c[W-1:0];
            res_status[STATUS_N_BIT] = prod_c[AW-1];
            res_status[STATUS_Z_BIT] = (prod_c == '0);
            res_status[STATUS_C_BIT] = (op_q == MD_MULTU) && (prod_c[AW-1:W] != '0);
            res_status[STATUS_V_BIT] = (op_q == MD_MULT) && (prod_c[AW-1:W] != {W{prod_c[W-1]}});
        end else begin
            res_hi                   = rem_c;
            res_lo                   = quot_c;
            res_status[STATUS_N_BIT] = quot_c[W-1];
            res_status[STATUS_Z_BIT] = (quot_c == '0);
        end
    end

    // FSM next-state and register updates
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        special_d = special_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        status_d  = status_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    op_d      = op;
                    opb_d     = b_abs;
                    neg_d     = sgn && (a[W-1] ^ b[W-1]);
                    neg_rem_d = sgn && a[W-1];
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    special_d = 1'b0;
                    acc_d     = {{W{1'b0}}, a_abs};
                    state_d   = MD_CALC;
                    // Special divides skip iteration with the final value preloaded
                    if (div_zero) begin
                        special_d = 1'b1;
                        acc_d     = {a, {W{1'b1}}};
                        state_d   = MD_FIX;
                    end else if (div_ovf) begin
                        special_d = 1'b1;
                        acc_d     = {{W{1'b0}}, MIN_NEG};
                        state_d   = MD_FIX;
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            MD_CALC: begin
                acc_d = op_q[1] ? div_next : mul_next;
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(W - 1)) state_d = MD_FIX;
            end
            MD_FIX: begin
                hi_d     = res_hi;
                lo_d     = res_lo;
                status_d = res_status;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                cnt_d    = '0;
                state_d  = MD_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = MD_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            op_q      <= MD_MULT;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            special_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            status_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            special_q <= special_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            status_q  <= status_d;
        end
    end

endmodule
